// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU types and helpers (divider FSM states, counter width).
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_div_t;

    // Width of a counter that must reach n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_secuencial_paso_division.sv
`default_nettype none
// ============================================================================
// Module : paso_division
// Brief  : One restoring-division step: trial subtract, keep or restore.
// Rev    : 1.0  initial release
// ============================================================================
module paso_division #(
    parameter int N = 4
) (
    input  logic [N:0]   i_r,
    input  logic [N-1:0] i_divisor,
    output logic [N:0]   o_r,
    output logic         o_q
);

    logic [N:0] w_diff;
    logic       w_neg;

    assign w_diff = i_r - {1'b0, i_divisor};
    assign w_neg  = w_diff[N];
    assign o_r    = w_neg ? i_r : w_diff;
    assign o_q    = ~w_neg;

endmodule
`default_nettype wire

// File: rtl/divisor_secuencial.sv
`default_nettype none
// ============================================================================
// Module : divisor_secuencial
// Brief  : Multi-cycle unsigned restoring divider with start/busy/done.
// Rev    : 1.0  initial release
// ============================================================================
module divisor_secuencial
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] aIn,
    input  logic [N-1:0] bIn,
    output logic [N-1:0] qOut,
    output logic [N-1:0] rOut,
    output logic         busy,
    output logic         done,
    output logic         ZeroDivFlag
);

    localparam int CW = cnt_width(N);

    estado_div_t   r_state;
    logic [N-1:0]  r_dividend;
    logic [N-1:0]  r_divisor;
    logic [N-1:0]  r_quot;
    logic [N:0]    r_rem;
    logic [CW-1:0] r_cnt;

    logic [N:0]    w_rshift;
    logic [N:0]    w_rnext;
    logic          w_qbit;
    logic          w_last;

    assign w_rshift = {r_rem[N-1:0], r_dividend[N-1]};
    assign w_last   = (r_cnt == CW'(N - 1));

    paso_division #(.N(N)) u_paso (
        .i_r       (w_rshift),
        .i_divisor (r_divisor),
        .o_r       (w_rnext),
        .o_q       (w_qbit)
    );

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

    // Results are latched on the edge entering DONE so they are valid with done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            qOut        <= '0;
            rOut        <= '0;
            ZeroDivFlag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dividend <= aIn;
                        r_divisor  <= bIn;
                        r_quot     <= '0;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        if (bIn == '0) begin
                            r_state     <= DONE;
                            qOut        <= '1;
                            rOut        <= aIn;
                            ZeroDivFlag <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_dividend <= {r_dividend[N-2:0], 1'b0};
                    r_rem      <= w_rnext;
                    r_quot     <= {r_quot[N-2:0], w_qbit};
                    r_cnt      <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state     <= DONE;
                        qOut        <= {r_quot[N-2:0], w_qbit};
                        rOut        <= w_rnext[N-1:0];
                        ZeroDivFlag <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
